// File: rtl/pcc_pkg.sv
// pcc_pkg: shared state type, direction indices and the clamped axis-step helper
// for the paint cursor controller.
package pcc_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  localparam int COLOR_W = 12;

  // One step along an axis; opposing requests cancel and the grid edges clamp.
  function automatic logic [7:0] step_axis(input logic [7:0] pos,
                                           input logic       dec,
                                           input logic       inc,
                                           input logic [7:0] max_pos);
    logic [7:0] res;
    res = pos;
    if (dec && !inc && (pos != 8'd0)) begin
      res = pos - 8'd1;
    end else if (inc && !dec && (pos != max_pos)) begin
      res = pos + 8'd1;
    end else begin
      res = pos;
    end
    return res;
  endfunction

endpackage

// File: rtl/pcc_key_event.sv
// pcc_key_event: rising-edge detector for one direction button, plus a hold
// counter that re-fires the event while held when PCC_AUTOREPEAT_EN is defined.
module pcc_key_event
`ifdef PCC_AUTOREPEAT_EN
#(
  parameter int RPT_DLY = 25_000_000,
  parameter int RPT_PER = 5_000_000
)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic lvl_i,
  input  logic run_i,
  output logic ev_o
);

  logic lvl_q;
  logic rise;

  // The level register tracks the button in every state so no stale edge survives a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q <= 1'b0;
    end else begin
      lvl_q <= lvl_i;
    end
  end

  assign rise = lvl_i & ~lvl_q;

`ifdef PCC_AUTOREPEAT_EN
  localparam int CNT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DLY_C   = CNT_W'(RPT_DLY);
  localparam logic [CNT_W-1:0] PER_C   = CNT_W'(RPT_PER);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rep_q, rep_d;
  logic             fire;

  // cnt_q counts cycles since the edge or the last repeat; zero means idle.
  always_comb begin
    cnt_d = '0;
    rep_d = 1'b0;
    fire  = 1'b0;
    if (!run_i || !lvl_i) begin
      cnt_d = '0;
      rep_d = 1'b0;
    end else if (rise) begin
      cnt_d = CNT_ONE;
      rep_d = 1'b0;
    end else if (cnt_q == '0) begin
      cnt_d = '0;
      rep_d = 1'b0;
    end else if (cnt_q == (rep_q ? PER_C : DLY_C)) begin
      fire  = 1'b1;
      cnt_d = CNT_ONE;
      rep_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
      rep_d = rep_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      rep_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rep_q <= rep_d;
    end
  end

  assign ev_o = run_i & (rise | fire);
`else
  assign ev_o = run_i & rise;
`endif

endmodule

// File: rtl/paint_cursor_ctrl.sv
// paint_cursor_ctrl: cursor movement, paint writes and full-screen clear sweep into VRAM.
// Auto-repeat of held direction buttons is built in when PCC_AUTOREPEAT_EN is defined.
module paint_cursor_ctrl
  import pcc_pkg::*;
#(
  parameter int                 H_RES    = 160,
  parameter int                 V_RES    = 120,
  parameter int                 ADDR_W   = 15,
  parameter logic [COLOR_W-1:0] BG_COLOR = 12'hFFF
`ifdef PCC_AUTOREPEAT_EN
  ,
  parameter int                 RPT_DLY  = 25_000_000,
  parameter int                 RPT_PER  = 5_000_000
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         dir_lvl,
  input  logic               draw,
  input  logic               clr,
  input  logic [COLOR_W-1:0] color,
  output logic [ADDR_W-1:0]  waddr,
  output logic [COLOR_W-1:0] wdata,
  output logic               we,
  output logic [7:0]         cursor_x,
  output logic [6:0]         cursor_y,
  output logic               busy
);

  localparam int SWP_W = ADDR_W + 1;
  localparam logic [SWP_W-1:0] SWP_END = SWP_W'(H_RES * V_RES);
  localparam logic [SWP_W-1:0] SWP_ONE = SWP_W'(1);
  localparam logic [7:0]       X_MAX   = 8'(H_RES - 1);
  localparam logic [7:0]       Y_MAX   = 8'(V_RES - 1);
  localparam logic [7:0]       X_MID   = 8'(H_RES / 2);
  localparam logic [6:0]       Y_MID   = 7'(V_RES / 2);

  state_e               state_q, state_d;
  logic [7:0]           x_q, x_d;
  logic [6:0]           y_q, y_d;
  logic [ADDR_W-1:0]    waddr_q, waddr_d;
  logic [COLOR_W-1:0]   wdata_q, wdata_d;
  logic                 we_q, we_d;
  logic                 busy_q, busy_d;
  logic [SWP_W-1:0]     swp_q, swp_d;
  logic                 draw_q;

  logic [3:0]           ev;
  logic                 run;
  logic [7:0]           nx;
  logic [6:0]           ny;
  logic [ADDR_W-1:0]    addr_new;

  assign run = (state_q == RUN);

  for (genvar i = 0; i < 4; i++) begin : g_key
`ifdef PCC_AUTOREPEAT_EN
    pcc_key_event #(
      .RPT_DLY (RPT_DLY),
      .RPT_PER (RPT_PER)
    ) u_key (
      .clk   (clk),
      .rst   (rst),
      .lvl_i (dir_lvl[i]),
      .run_i (run),
      .ev_o  (ev[i])
    );
`else
    pcc_key_event u_key (
      .clk   (clk),
      .rst   (rst),
      .lvl_i (dir_lvl[i]),
      .run_i (run),
      .ev_o  (ev[i])
    );
`endif
  end

  assign nx = step_axis(x_q, ev[DIR_LEFT], ev[DIR_RIGHT], X_MAX);
  assign ny = 7'(step_axis({1'b0, y_q}, ev[DIR_UP], ev[DIR_DOWN], Y_MAX));

  // y*160 is split into two shifts; other line widths fall back to a multiply.
  always_comb begin
    addr_new = '0;
    if (H_RES == 32'd160) begin
      addr_new = (ADDR_W'(ny) << 3'd7) + (ADDR_W'(ny) << 3'd5) + ADDR_W'(nx);
    end else begin
      addr_new = ADDR_W'(ny) * ADDR_W'(H_RES) + ADDR_W'(nx);
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    busy_d  = busy_q;
    swp_d   = swp_q;
    case (state_q)
      CLEAR: begin
        if (swp_q == SWP_END) begin
          state_d = RUN;
          busy_d  = 1'b0;
        end else begin
          we_d    = 1'b1;
          waddr_d = ADDR_W'(swp_q);
          wdata_d = BG_COLOR;
          swp_d   = swp_q + SWP_ONE;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        busy_d = 1'b0;
        if (clr) begin
          // Address 0 goes out in the very next cycle; moves and paint are dropped.
          state_d = CLEAR;
          busy_d  = 1'b1;
          we_d    = 1'b1;
          waddr_d = '0;
          wdata_d = BG_COLOR;
          swp_d   = SWP_ONE;
        end else begin
          x_d = nx;
          y_d = ny;
          if (draw && ((|ev) || !draw_q)) begin
            we_d    = 1'b1;
            waddr_d = addr_new;
            wdata_d = color;
          end else begin
            we_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = CLEAR;
        busy_d  = 1'b1;
        swp_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      x_q     <= X_MID;
      y_q     <= Y_MID;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b1;
      swp_q   <= '0;
      draw_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      swp_q   <= swp_d;
      draw_q  <= draw;
    end
  end

  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign we       = we_q;
  assign cursor_x = x_q;
  assign cursor_y = y_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_paint_cursor_ctrl.sv
// tb_paint_cursor_ctrl: randomized and directed checks of paint_cursor_ctrl against a
// transaction-level cursor/paint model (default build, auto-repeat disabled).
module tb_paint_cursor_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  dir_lvl;
  logic        draw;
  logic        clr;
  logic [11:0] color;
  logic [14:0] waddr;
  logic [11:0] wdata;
  logic        we;
  logic [7:0]  cursor_x;
  logic [6:0]  cursor_y;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;
  int mx, my;
  bit mdraw;

  always #5 clk = ~clk;

  paint_cursor_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .dir_lvl  (dir_lvl),
    .draw     (draw),
    .clr      (clr),
    .color    (color),
    .waddr    (waddr),
    .wdata    (wdata),
    .we       (we),
    .cursor_x (cursor_x),
    .cursor_y (cursor_y),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Expect H_RES*V_RES consecutive background writes 0..19199, then busy low.
  task automatic sweep_check(input string tag);
    int idx  = 0;
    int bad  = 0;
    bit done = 1'b0;
    for (int c = 0; c < 19400 && !done; c++) begin
      @(negedge clk);
      if (we === 1'b1) begin
        if (waddr !== 15'(idx) || wdata !== 12'hFFF || busy !== 1'b1) bad++;
        idx++;
      end else if (idx > 0) begin
        done = 1'b1;
      end
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_len"}, idx, 19200);
    check({tag, "_bad"}, bad, 0);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  // One press of the direction set d (held one cycle) with draw level drw.
  task automatic step(input logic [3:0] d, input logic drw, input logic [11:0] col, input string tag);
    int ex = mx;
    int ey = my;
    bit wr;
    if (d[0] && !d[1] && ey > 0) ey = ey - 1;
    else if (d[1] && !d[0] && ey < 119) ey = ey + 1;
    if (d[2] && !d[3] && ex > 0) ex = ex - 1;
    else if (d[3] && !d[2] && ex < 159) ex = ex + 1;
    wr = drw && ((d != 4'd0) || !mdraw);
    @(negedge clk);
    dir_lvl = d;
    draw    = drw;
    color   = col;
    @(negedge clk);
    check({tag, "_x"}, 32'(cursor_x), ex);
    check({tag, "_y"}, 32'(cursor_y), ey);
    check({tag, "_we"}, 32'(we), 32'(wr));
    if (wr) begin
      check({tag, "_waddr"}, 32'(waddr), ey * 160 + ex);
      check({tag, "_wdata"}, 32'(wdata), 32'(col));
    end
    dir_lvl = 4'd0;
    @(negedge clk);
    check({tag, "_idle_we"}, 32'(we), 32'd0);
    mx    = ex;
    my    = ey;
    mdraw = drw;
  endtask

  initial begin
    bit found;
    rst     = 1'b1;
    dir_lvl = 4'd0;
    draw    = 1'b0;
    clr     = 1'b0;
    color   = 12'h000;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_we", 32'(we), 32'd0);
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    check("rst_x", 32'(cursor_x), 32'd80);
    check("rst_y", 32'(cursor_y), 32'd60);
    rst   = 1'b0;
    mx    = 80;
    my    = 60;
    mdraw = 1'b0;
    sweep_check("sweep0");

    step(4'b1000, 1'b1, 12'hF00, "right_draw");
    step(4'b0000, 1'b0, 12'h000, "draw_off");
    for (int i = 0; i < 90; i++) step(4'b0101, 1'b0, 12'h000, "to_origin");
    step(4'b0101, 1'b1, 12'h0A5, "origin_clamp");
    step(4'b0000, 1'b0, 12'h000, "draw_off2");
    for (int i = 0; i < 170; i++) step(4'b1010, 1'b0, 12'h000, "to_corner");
    step(4'b0010, 1'b0, 12'h000, "down_clamp");
    step(4'b1000, 1'b1, 12'h123, "right_clamp_draw");
    step(4'b0011, 1'b1, 12'h456, "up_down");
    step(4'b0100, 1'b0, 12'h000, "left");
    step(4'b1001, 1'b1, 12'h789, "up_right");
    step(4'b1100, 1'b0, 12'h000, "left_right");
    step(4'b0000, 1'b1, 12'h3C3, "draw_rise_only");

    for (int i = 0; i < 300; i++) begin
      step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 12'($urandom), "rnd");
    end

    // Clear request beats a same-cycle move; sweep then interrupted by reset.
    @(negedge clk);
    clr     = 1'b1;
    dir_lvl = 4'b1000;
    draw    = 1'b0;
    @(negedge clk);
    check("clr_we", 32'(we), 32'd1);
    check("clr_waddr", 32'(waddr), 32'd0);
    check("clr_wdata", 32'(wdata), 32'hFFF);
    check("clr_busy", 32'(busy), 32'd1);
    check("clr_x", 32'(cursor_x), mx);
    check("clr_y", 32'(cursor_y), my);
    clr     = 1'b0;
    dir_lvl = 4'd0;
    mdraw   = 1'b0;
    found   = 1'b0;
    for (int c = 0; c < 6000 && !found; c++) begin
      @(negedge clk);
      if (we === 1'b1 && waddr === 15'd5000) found = 1'b1;
    end
    check("clr_reach_5000", 32'(found), 32'd1);
    check("clr_keep_x", 32'(cursor_x), mx);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd1);
    check("midrst_we", 32'(we), 32'd0);
    check("midrst_waddr", 32'(waddr), 32'd0);
    check("midrst_x", 32'(cursor_x), 32'd80);
    check("midrst_y", 32'(cursor_y), 32'd60);
    @(negedge clk);
    rst = 1'b0;
    mx  = 80;
    my  = 60;
    sweep_check("sweep1");

    for (int i = 0; i < 50; i++) begin
      step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 12'($urandom), "rnd2");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
